// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive engine: one-hot FSM states,
// prescale floor, parity-type encodings and the 3-sample majority helper.
package uart_pkg;

  typedef enum logic [5:0] {
    StIdle   = 6'b000001,
    StStart  = 6'b000010,
    StData   = 6'b000100,
    StParity = 6'b001000,
    StStop   = 6'b010000,
    StBreak  = 6'b100000
  } state_e;

  localparam int unsigned MIN_PRESCALE = 4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-tap oversampler; pulses w_bit_done at edge H+1
// with the majority of the samples taken at edges H-1, H and H+1.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_active,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_rx,
  output logic                  o_bit_done,
  output logic                  o_bit_val
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] r_edge_cnt;
  logic                  r_tap0;
  logic                  r_tap1;
  logic [PRESCALE_W-1:0] w_half;
  logic [PRESCALE_W-1:0] w_last;

  assign w_half = i_prescale >> 1;
  assign w_last = i_prescale - ONE;

  // The start-detect cycle is edge 0, so the counter reloads at 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= '0;
      r_tap0     <= 1'b1;
      r_tap1     <= 1'b1;
    end else if (i_start) begin
      r_edge_cnt <= ONE;
    end else if (i_active) begin
      r_edge_cnt <= (r_edge_cnt == w_last) ? '0 : r_edge_cnt + ONE;
      if (r_edge_cnt == w_half - ONE) r_tap0 <= i_rx;
      if (r_edge_cnt == w_half)       r_tap1 <= i_rx;
    end else begin
      r_edge_cnt <= '0;
    end
  end

  assign o_bit_done = i_active && (r_edge_cnt == w_half + ONE);
  assign o_bit_val  = majority3(r_tap0, r_tap1, i_rx);

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: frame FSM, bit counter, deserialiser, parity and stop
// checking on top of the oversampling bit sampler.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_in,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  input  logic                  i_stop2,
  output logic [DATA_W-1:0]     o_p_data,
  output logic                  o_data_valid,
  output logic                  o_par_err,
  output logic                  o_stp_err,
  output logic                  o_busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [PRESCALE_W-1:0] MIN_P = PRESCALE_W'(MIN_PRESCALE);

  state_e                r_state;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_stop2;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [DATA_W-1:0]     r_shift;
  logic                  r_par_bad;
  logic                  r_stop_bad;
  logic                  r_stop_idx;
  logic [DATA_W-1:0]     r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  logic [PRESCALE_W-1:0] w_prescale_even;
  logic [PRESCALE_W-1:0] w_prescale_eff;
  logic                  w_start_det;
  logic                  w_active;
  logic                  w_bit_done;
  logic                  w_bit_val;
  logic                  w_par_xor;
  logic                  w_stop_bad;

  assign w_prescale_even = i_prescale & {{(PRESCALE_W-1){1'b1}}, 1'b0};
  assign w_prescale_eff  = (w_prescale_even < MIN_P) ? MIN_P : w_prescale_even;
  assign w_start_det     = (r_state == StIdle) && !i_rx_in;
  assign w_active        = (r_state != StIdle) && (r_state != StBreak);
  assign w_par_xor       = (^r_shift) ^ w_bit_val;
  assign w_stop_bad      = r_stop_bad | ~w_bit_val;

  uart_rx_sampler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_sampler (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (w_start_det),
    .i_active   (w_active),
    .i_prescale (r_prescale),
    .i_rx       (i_rx_in),
    .o_bit_done (w_bit_done),
    .o_bit_val  (w_bit_val)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_prescale   <= MIN_P;
      r_par_en     <= 1'b0;
      r_par_typ    <= PAR_EVEN;
      r_stop2      <= 1'b0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_stop_bad   <= 1'b0;
      r_stop_idx   <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!i_rx_in) begin
            r_state    <= StStart;
            r_prescale <= w_prescale_eff;
            r_par_en   <= i_par_en;
            r_par_typ  <= i_par_typ;
            r_stop2    <= i_stop2;
            r_bit_cnt  <= '0;
            r_par_bad  <= 1'b0;
            r_stop_bad <= 1'b0;
            r_stop_idx <= 1'b0;
          end
        end
        StStart: begin
          if (w_bit_done) r_state <= w_bit_val ? StIdle : StData;
        end
        StData: begin
          if (w_bit_done) begin
            r_shift <= {w_bit_val, r_shift[DATA_W-1:1]};
            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
              r_bit_cnt <= '0;
              r_state   <= r_par_en ? StParity : StStop;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
        end
        StParity: begin
          if (w_bit_done) begin
            r_par_bad <= (r_par_typ == PAR_EVEN) ? w_par_xor : ~w_par_xor;
            r_state   <= StStop;
          end
        end
        StStop: begin
          if (w_bit_done) begin
            if (r_stop2 && !r_stop_idx) begin
              r_stop_idx <= 1'b1;
              r_stop_bad <= w_stop_bad;
            end else if (w_stop_bad) begin
              r_stp_err <= 1'b1;
              r_state   <= StBreak;
            end else if (r_par_bad) begin
              r_par_err <= 1'b1;
              r_state   <= StIdle;
            end else begin
              r_data_valid <= 1'b1;
              r_p_data     <= r_shift;
              r_state      <= StIdle;
            end
          end
        end
        // Hold off re-arming until the line recovers, so a stuck-low line is one error.
        StBreak: begin
          if (i_rx_in) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_p_data     = r_p_data;
  assign o_data_valid = r_data_valid;
  assign o_par_err    = r_par_err;
  assign o_stp_err    = r_stp_err;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: plays per-cycle line waveforms and
// checks pulse timing, data and error reporting against hand-derived values.
module tb_uart_rx_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       stop2;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic       line[$];
  int         dv_at[$];
  logic [7:0] dv_dat[$];
  int         pe_at[$];
  int         se_at[$];
  logic       busy_q[$];

  always #5 clk = ~clk;

  uart_rx_engine #(
    .DATA_W     (8),
    .PRESCALE_W (6)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_in      (rx),
    .i_prescale   (prescale),
    .i_par_en     (par_en),
    .i_par_typ    (par_typ),
    .i_stop2      (stop2),
    .o_p_data     (p_data),
    .o_data_valid (data_valid),
    .o_par_err    (par_err),
    .o_stp_err    (stp_err),
    .o_busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  function automatic logic [7:0] d_at(input logic [7:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 8'hxx;
  endfunction

  function automatic logic b_at(input logic q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 1'bx;
  endfunction

  task automatic add_bit(input logic v, input int p);
    repeat (p) line.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] d, input int p, input bit pen, input logic pbit,
                           input logic stop_a, input bit two_stops, input logic stop_b);
    add_bit(1'b0, p);
    for (int i = 0; i < 8; i++) add_bit(d[i], p);
    if (pen) add_bit(pbit, p);
    add_bit(stop_a, p);
    if (two_stops) add_bit(stop_b, p);
  endtask

  // Index i = cycle offset from the first driven sample; outputs read at the
  // negedge reflect the registers of that cycle.
  task automatic play();
    dv_at.delete(); dv_dat.delete(); pe_at.delete(); se_at.delete(); busy_q.delete();
    for (int i = 0; i < line.size(); i++) begin
      @(negedge clk);
      if (data_valid) begin
        dv_at.push_back(i);
        dv_dat.push_back(p_data);
      end
      if (par_err) pe_at.push_back(i);
      if (stp_err) se_at.push_back(i);
      busy_q.push_back(busy);
      rx = line[i];
    end
    line.delete();
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_p_data", 32'(p_data), 32'h0);
    check("rst_dv", 32'(data_valid), 32'h0);
    check("rst_par_err", 32'(par_err), 32'h0);
    check("rst_stp_err", 32'(stp_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // P=8, 8N1, 0xA5
    add_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_bit(1'b1, 12);
    play();
    check("a5_dv_count", 32'(dv_at.size()), 32'd1);
    check("a5_dv_time", 32'(q_at(dv_at, 0)), 32'd78);
    check("a5_data", 32'(d_at(dv_dat, 0)), 32'hA5);
    check("a5_errs", 32'(pe_at.size() + se_at.size()), 32'd0);
    check("a5_busy_t1", 32'(b_at(busy_q, 1)), 32'd1);
    check("a5_busy_t78", 32'(b_at(busy_q, 78)), 32'd0);
    check("a5_hold", 32'(p_data), 32'hA5);

    // P=16, odd parity, 0x3C: good parity bit 1, then bad parity bit 0
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b1;
    add_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_bit(1'b1, 12);
    play();
    check("odd_ok_dv_time", 32'(q_at(dv_at, 0)), 32'd170);
    check("odd_ok_data", 32'(d_at(dv_dat, 0)), 32'h3C);
    check("odd_ok_pe", 32'(pe_at.size()), 32'd0);
    add_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add_bit(1'b1, 12);
    play();
    check("odd_bad_pe_time", 32'(q_at(pe_at, 0)), 32'd170);
    check("odd_bad_pe_count", 32'(pe_at.size()), 32'd1);
    check("odd_bad_no_dv", 32'(dv_at.size()), 32'd0);
    check("odd_bad_hold", 32'(p_data), 32'h3C);

    // P=8, two stops, second stop low, then line stuck low 40 cycles
    prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b1;
    add_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_bit(1'b0, 40);
    add_bit(1'b1, 12);
    play();
    check("stp_time", 32'(q_at(se_at, 0)), 32'd86);
    check("stp_count", 32'(se_at.size()), 32'd1);
    check("stp_no_dv_pe", 32'(dv_at.size() + pe_at.size()), 32'd0);
    check("break_busy", 32'(b_at(busy_q, 127)), 32'd1);
    check("break_release", 32'(b_at(busy_q, 130)), 32'd0);

    // P=8, 2-cycle glitch on idle line
    stop2 = 1'b0;
    add_bit(1'b0, 2);
    add_bit(1'b1, 20);
    play();
    check("glitch_busy_t5", 32'(b_at(busy_q, 5)), 32'd1);
    check("glitch_busy_t6", 32'(b_at(busy_q, 6)), 32'd0);
    check("glitch_pulses", 32'(dv_at.size() + pe_at.size() + se_at.size()), 32'd0);

    // Back-to-back 0x00 then 0xFF
    add_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_bit(1'b1, 12);
    play();
    check("b2b_count", 32'(dv_at.size()), 32'd2);
    check("b2b_t0", 32'(q_at(dv_at, 0)), 32'd78);
    check("b2b_t1", 32'(q_at(dv_at, 1)), 32'd158);
    check("b2b_d0", 32'(d_at(dv_dat, 0)), 32'h00);
    check("b2b_d1", 32'(d_at(dv_dat, 1)), 32'hFF);

    // 0x96 with data bit 2 inverted for one cycle at its middle edge
    add_frame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_bit(1'b1, 12);
    line[28] = 1'b0;
    play();
    check("vote_dv_time", 32'(q_at(dv_at, 0)), 32'd78);
    check("vote_data", 32'(d_at(dv_dat, 0)), 32'h96);

    // Reset in the middle of the data bits
    add_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    while (line.size() > 30) void'(line.pop_back());
    play();
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_p_data", 32'(p_data), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pulses", 32'({data_valid, par_err, stp_err}), 32'd0);
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    add_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_bit(1'b1, 12);
    play();
    check("post_rst_dv_time", 32'(q_at(dv_at, 0)), 32'd78);
    check("post_rst_data", 32'(d_at(dv_dat, 0)), 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
